// File: rtl/piradip_cdc_hsk_responder_if.sv
// Handshake bundle between a 4-phase CDC initiator/downstream sink and the responder.
// slave = responder view; master = environment (initiator + downstream consumer).
interface piradip_cdc_hsk_responder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             src_req;
  logic [WIDTH-1:0] src_data;
  logic             src_ack;
  logic [WIDTH-1:0] dst_data;
  logic             dst_valid;
  logic             dst_ready;

  modport master (
    output src_req,
    output src_data,
    output dst_ready,
    input  src_ack,
    input  dst_data,
    input  dst_valid
  );

  modport slave (
    input  src_req,
    input  src_data,
    input  dst_ready,
    output src_ack,
    output dst_data,
    output dst_valid
  );
endinterface

// File: rtl/piradip_cdc_hsk_responder.sv
// 4-phase req/ack CDC responder: capture STAGES edges after req is sampled, ack from a flop.
// Backpressure: dst_ready=0 holds the word and (ACK_EARLY=0) withholds ack from the initiator.
module piradip_cdc_hsk_responder #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      STAGES      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter bit               ACK_EARLY   = 1'b0,
  parameter int unsigned      COUNT_WIDTH = 16
) (
  input  logic                       dst_clk,
  input  logic                       dst_rstn,
  piradip_cdc_hsk_responder_if.slave hsk,
  output logic [COUNT_WIDTH-1:0]     xfer_count,
  output logic                       proto_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [STAGES-1:0]      req_sync;
  logic                   req_s;
  logic                   ack_q;
  logic                   ack_nxt;
  logic                   vld_q;
  logic                   vld_nxt;
  logic [WIDTH-1:0]       data_q;
  logic [WIDTH-1:0]       data_nxt;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_nxt;
  logic                   err_q;
  logic                   err_nxt;
  logic                   xfer;
  logic                   cap_ok;

  // Only crossing point: src_req enters a plain flop chain, nothing else is sampled early.
  always_ff @(posedge dst_clk or negedge dst_rstn) begin
    if (!dst_rstn) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[STAGES-2:0], hsk.src_req};
    end
  end

  assign req_s  = req_sync[STAGES-1];
  assign xfer   = vld_q & hsk.dst_ready;
  // A new word may load into the output slot on the same edge the old one leaves.
  assign cap_ok = req_s & (~vld_q | xfer);

  always_ff @(posedge dst_clk or negedge dst_rstn) begin
    if (!dst_rstn) begin
      state  <= IDLE;
      ack_q  <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= RESET_VAL;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ack_q  <= ack_nxt;
      vld_q  <= vld_nxt;
      data_q <= data_nxt;
      cnt_q  <= cnt_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = ack_q;
    vld_nxt   = vld_q & ~xfer;
    data_nxt  = data_q;
    cnt_nxt   = cnt_q + COUNT_WIDTH'(xfer);
    err_nxt   = err_q;

    case (state)
      IDLE: begin
        if (cap_ok) begin
          data_nxt = hsk.src_data;
          vld_nxt  = 1'b1;
          if (ACK_EARLY) begin
            ack_nxt   = 1'b1;
            state_nxt = WAIT_REL;
          end else begin
            state_nxt = WAIT_RDY;
          end
        end
      end

      WAIT_RDY: begin
        // Initiator released req before we acked: flag it but still deliver the word.
        if (!req_s) begin
          err_nxt = 1'b1;
        end
        if (xfer) begin
          ack_nxt   = 1'b1;
          state_nxt = WAIT_REL;
        end
      end

      WAIT_REL: begin
        if (!req_s) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        ack_nxt   = 1'b0;
      end
    endcase
  end

  assign hsk.src_ack   = ack_q;
  assign hsk.dst_valid = vld_q;
  assign hsk.dst_data  = data_q;
  assign xfer_count    = cnt_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_piradip_cdc_hsk_responder.sv
// Bench for piradip_cdc_hsk_responder: three instances (ack-late/16b count, ack-early, 4b count).
// Scoreboard queues per instance model the ordered word stream and the transfer count.
module tb_piradip_cdc_hsk_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_r [3];
  logic [31:0] dat_r [3];
  logic        rdy_r [3];

  wire         ack_w [3];
  wire         vld_w [3];
  wire  [31:0] dout_w [3];
  wire  [15:0] cnt_w [3];
  wire         err_w [3];

  wire  [15:0] cnt0;
  wire  [15:0] cnt1;
  wire  [3:0]  cnt2;
  wire         err0;
  wire         err1;
  wire         err2;

  piradip_cdc_hsk_responder_if #(.WIDTH(32)) if0 ();
  piradip_cdc_hsk_responder_if #(.WIDTH(32)) if1 ();
  piradip_cdc_hsk_responder_if #(.WIDTH(32)) if2 ();

  assign if0.src_req = req_r[0];  assign if0.src_data = dat_r[0];  assign if0.dst_ready = rdy_r[0];
  assign if1.src_req = req_r[1];  assign if1.src_data = dat_r[1];  assign if1.dst_ready = rdy_r[1];
  assign if2.src_req = req_r[2];  assign if2.src_data = dat_r[2];  assign if2.dst_ready = rdy_r[2];

  assign ack_w[0] = if0.src_ack;  assign vld_w[0] = if0.dst_valid;  assign dout_w[0] = if0.dst_data;
  assign ack_w[1] = if1.src_ack;  assign vld_w[1] = if1.dst_valid;  assign dout_w[1] = if1.dst_data;
  assign ack_w[2] = if2.src_ack;  assign vld_w[2] = if2.dst_valid;  assign dout_w[2] = if2.dst_data;
  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = cnt1;
  assign cnt_w[2] = {12'd0, cnt2};
  assign err_w[0] = err0;
  assign err_w[1] = err1;
  assign err_w[2] = err2;

  piradip_cdc_hsk_responder #(
    .WIDTH(32), .STAGES(4), .RESET_VAL(32'hDEAD_BEEF), .ACK_EARLY(1'b0), .COUNT_WIDTH(16)
  ) u_dut0 (
    .dst_clk(clk), .dst_rstn(rst_n), .hsk(if0.slave), .xfer_count(cnt0), .proto_err(err0)
  );

  piradip_cdc_hsk_responder #(
    .WIDTH(32), .STAGES(4), .RESET_VAL(32'h0), .ACK_EARLY(1'b1), .COUNT_WIDTH(16)
  ) u_dut1 (
    .dst_clk(clk), .dst_rstn(rst_n), .hsk(if1.slave), .xfer_count(cnt1), .proto_err(err1)
  );

  piradip_cdc_hsk_responder #(
    .WIDTH(32), .STAGES(2), .RESET_VAL(32'h0000_005A), .ACK_EARLY(1'b0), .COUNT_WIDTH(4)
  ) u_dut2 (
    .dst_clk(clk), .dst_rstn(rst_n), .hsk(if2.slave), .xfer_count(cnt2), .proto_err(err2)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] expq [3][$];
  int          mcnt [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int cmask(input int i);
    return (i == 2) ? 32'h0000_000F : 32'h0000_FFFF;
  endfunction

  // Scoreboard: every accepted word must be the oldest one offered; count tracks acceptances.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        expq[i].delete();
        mcnt[i] = 0;
      end else begin
        chk($sformatf("cnt%0d", i), 32'(cnt_w[i]), 32'(mcnt[i] & cmask(i)));
        if (vld_w[i] && rdy_r[i]) begin
          if (expq[i].size() == 0) begin
            chk($sformatf("dup%0d", i), 32'd1, 32'd0);
          end else begin
            chk($sformatf("data%0d", i), dout_w[i], expq[i].pop_front());
          end
          mcnt[i] = mcnt[i] + 1;
        end
      end
    end
  end

  task automatic wait_ack(input int i, input logic val, input string tag);
    int n = 0;
    while (ack_w[i] !== val && n < 200) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(ack_w[i]), 32'(val));
  endtask

  task automatic wait_vld(input int i, input logic val, input string tag);
    int n = 0;
    while (vld_w[i] !== val && n < 200) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(vld_w[i]), 32'(val));
  endtask

  // Initiator model: full 4-phase cycle req up / ack up / req down / ack down.
  task automatic send(input int i, input logic [31:0] v);
    wait_ack(i, 1'b0, $sformatf("s%0d_idle", i));
    dat_r[i] = v;
    req_r[i] = 1'b1;
    expq[i].push_back(v);
    wait_ack(i, 1'b1, $sformatf("s%0d_ack_up", i));
    req_r[i] = 1'b0;
    wait_ack(i, 1'b0, $sformatf("s%0d_ack_dn", i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    bit          done;
    for (int i = 0; i < 3; i++) begin
      req_r[i] = 1'b0;
      dat_r[i] = 32'h0;
      rdy_r[i] = 1'b0;
    end

    // Reset with req already high on instance 0.
    req_r[0] = 1'b1;
    dat_r[0] = 32'hA5A5_0001;
    rdy_r[0] = 1'b1;
    tick(2);
    chk("rst_ack", 32'(ack_w[0]), 32'd0);
    chk("rst_vld", 32'(vld_w[0]), 32'd0);
    chk("rst_data", dout_w[0], 32'hDEAD_BEEF);
    chk("rst_cnt", 32'(cnt_w[0]), 32'd0);
    chk("rst_err", 32'(err_w[0]), 32'd0);
    chk("rst_data2", dout_w[2], 32'h0000_005A);
    rst_n = 1'b1;
    expq[0].push_back(32'hA5A5_0001);
    tick(1);
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      chk($sformatf("t1_vld_e%0d", e), 32'(vld_w[0]), 32'(e == 4));
    end
    chk("t1_data", dout_w[0], 32'hA5A5_0001);
    chk("t1_ack_early", 32'(ack_w[0]), 32'd0);
    tick(1);
    chk("t1_ack_up", 32'(ack_w[0]), 32'd1);
    chk("t1_vld_clr", 32'(vld_w[0]), 32'd0);
    req_r[0] = 1'b0;
    tick(1);
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      chk($sformatf("t1_ack_e%0d", e), 32'(ack_w[0]), 32'(e != 4));
    end
    chk("t1_cnt", 32'(cnt_w[0]), 32'd1);

    // Backpressure: word and ack held while downstream stalls.
    rdy_r[0] = 1'b0;
    dat_r[0] = 32'h0000_1234;
    req_r[0] = 1'b1;
    expq[0].push_back(32'h0000_1234);
    wait_vld(0, 1'b1, "t2_cap");
    for (int c = 0; c < 20; c++) begin
      chk("t2_vld_hold", 32'(vld_w[0]), 32'd1);
      chk("t2_data_hold", dout_w[0], 32'h0000_1234);
      chk("t2_ack_hold", 32'(ack_w[0]), 32'd0);
      tick(1);
    end
    rdy_r[0] = 1'b1;
    tick(1);
    chk("t2_ack_up", 32'(ack_w[0]), 32'd1);
    chk("t2_vld_clr", 32'(vld_w[0]), 32'd0);
    rdy_r[0] = 1'b0;
    req_r[0] = 1'b0;
    wait_ack(0, 1'b0, "t2_ack_dn");

    // Ten back-to-back transfers with random downstream readiness.
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          send(0, 32'(k));
          tick(int'($urandom_range(0, 3)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rdy_r[0] = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rdy_r[0] = 1'b0;
    tick(1);
    chk("t3_cnt", 32'(cnt_w[0]), 32'd10);
    chk("t3_err", 32'(err_w[0]), 32'd0);
    chk("t3_drain", 32'(expq[0].size()), 32'd0);

    // Random words through the ack-early instance.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          send(1, $urandom);
          tick(int'($urandom_range(0, 2)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rdy_r[1] = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rdy_r[1] = 1'b1;
    wait_vld(1, 1'b0, "t3b_drain_vld");
    rdy_r[1] = 1'b0;
    tick(1);
    chk("t3b_cnt", 32'(cnt_w[1]), 32'd20);
    chk("t3b_drain", 32'(expq[1].size()), 32'd0);

    // Ack-early: second request parked until the first word is accepted.
    do_reset();
    dat_r[1] = 32'h11;
    req_r[1] = 1'b1;
    expq[1].push_back(32'h11);
    wait_ack(1, 1'b1, "t4_ack_up");
    chk("t4_vld", 32'(vld_w[1]), 32'd1);
    chk("t4_data", dout_w[1], 32'h11);
    req_r[1] = 1'b0;
    wait_ack(1, 1'b0, "t4_ack_dn");
    dat_r[1] = 32'h22;
    req_r[1] = 1'b1;
    expq[1].push_back(32'h22);
    for (int c = 0; c < 8; c++) begin
      tick(1);
      chk("t4_ack_park", 32'(ack_w[1]), 32'd0);
      chk("t4_data_park", dout_w[1], 32'h11);
    end
    rdy_r[1] = 1'b1;
    tick(1);
    rdy_r[1] = 1'b0;
    chk("t4_data_new", dout_w[1], 32'h22);
    chk("t4_vld_new", 32'(vld_w[1]), 32'd1);
    chk("t4_ack_new", 32'(ack_w[1]), 32'd1);
    chk("t4_cnt1", 32'(cnt_w[1]), 32'd1);
    req_r[1] = 1'b0;
    wait_ack(1, 1'b0, "t4_ack_dn2");
    rdy_r[1] = 1'b1;
    tick(1);
    rdy_r[1] = 1'b0;
    chk("t4_vld_end", 32'(vld_w[1]), 32'd0);
    chk("t4_cnt2", 32'(cnt_w[1]), 32'd2);

    // Early req release: sticky error, word still delivered exactly once.
    do_reset();
    v = $urandom;
    dat_r[0] = v;
    req_r[0] = 1'b1;
    expq[0].push_back(v);
    wait_vld(0, 1'b1, "t5_cap");
    req_r[0] = 1'b0;
    tick(6);
    chk("t5_err", 32'(err_w[0]), 32'd1);
    chk("t5_vld", 32'(vld_w[0]), 32'd1);
    chk("t5_ack", 32'(ack_w[0]), 32'd0);
    chk("t5_data", dout_w[0], v);
    rdy_r[0] = 1'b1;
    tick(1);
    chk("t5_vld_clr", 32'(vld_w[0]), 32'd0);
    chk("t5_ack_up", 32'(ack_w[0]), 32'd1);
    tick(1);
    chk("t5_ack_dn", 32'(ack_w[0]), 32'd0);
    tick(10);
    rdy_r[0] = 1'b0;
    chk("t5_no_recap", 32'(vld_w[0]), 32'd0);
    chk("t5_sticky", 32'(err_w[0]), 32'd1);
    chk("t5_cnt", 32'(cnt_w[0]), 32'd1);

    // Async reset while waiting for downstream (ack low, word pending).
    v = $urandom;
    dat_r[0] = v;
    req_r[0] = 1'b1;
    expq[0].push_back(v);
    wait_vld(0, 1'b1, "t6a_cap");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6a_ack", 32'(ack_w[0]), 32'd0);
    chk("t6a_vld", 32'(vld_w[0]), 32'd0);
    chk("t6a_data", dout_w[0], 32'hDEAD_BEEF);
    chk("t6a_cnt", 32'(cnt_w[0]), 32'd0);
    chk("t6a_err", 32'(err_w[0]), 32'd0);
    req_r[0] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("t6a_no_recap", 32'(vld_w[0]), 32'd0);

    // Async reset while acked and waiting for release (ack-early, word pending).
    v = $urandom | 32'h1;
    dat_r[1] = v;
    req_r[1] = 1'b1;
    expq[1].push_back(v);
    wait_ack(1, 1'b1, "t6b_ack_up");
    chk("t6b_vld_pre", 32'(vld_w[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6b_ack", 32'(ack_w[1]), 32'd0);
    chk("t6b_vld", 32'(vld_w[1]), 32'd0);
    chk("t6b_data", dout_w[1], 32'h0);
    req_r[1] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Counter wrap on the 4-bit instance.
    rdy_r[2] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      send(2, $urandom);
    end
    tick(2);
    chk("t7_wrap", 32'(cnt_w[2]), 32'd1);
    chk("t7_drain", 32'(expq[2].size()), 32'd0);
    rdy_r[2] = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/piradip_cdc_hsk_responder.md
Name: piradip_cdc_hsk_responder

Overview:
- Destination-end responder for a 4-phase req/ack clock-domain-crossing handshake: synchronizes a remote request, captures the word the remote source holds stable, presents it downstream on valid/ready, then drives ack back.
- Sits in the destination clock domain, opposite an initiator that holds src_data stable from req rise until it sees ack.
- Single clock (dst_clk); the only crossing logic is the internal req synchronizer.

Parameters:
- WIDTH, 32, data word width.
- STAGES, 4, synchronizer flops on src_req (legal 2..8).
- RESET_VAL, 0, value of dst_data while reset or before the first capture.
- ACK_EARLY, 0. 0: ack on downstream acceptance. 1: ack on capture.
- COUNT_WIDTH, 16, width of the transfer counter.

Ports:
- dst_clk  in  1  destination clock.
- dst_rstn  in  1  asynchronous active-low reset.
- src_req  in  1  request from remote domain, asynchronous.
- src_data  in  WIDTH  remote data; stable while src_req=1 and until ack is seen.
- src_ack  out  1  registered acknowledge to remote domain.
- dst_data  out  WIDTH  captured word.
- dst_valid  out  1  dst_data holds an unaccepted word.
- dst_ready  in  1  downstream accept.
- xfer_count  out  COUNT_WIDTH  completed downstream transfers.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: dst_rstn=0 asynchronously forces all of the following: sync chain=0, state=IDLE, src_ack=0, dst_valid=0, dst_data=RESET_VAL, xfer_count=0, proto_err=0.
- Reset mid-operation: any pending word is discarded; ack drops immediately. The initiator must tolerate ack falling early.
- Sync: req_s is the output of the STAGES flop chain. If src_req is high at edge k, req_s=1 after edge k+STAGES-1.
- IDLE (src_ack=0):
  - On req_s=1 and dst_valid=0: dst_data<=src_data, dst_valid<=1.
  - ACK_EARLY=0: go to WAIT_RDY.
  - ACK_EARLY=1: src_ack<=1 and go to WAIT_REL.
  - Capture latency is therefore STAGES edges after src_req is first sampled high.
  - If req_s=1 but dst_valid=1 (possible only with ACK_EARLY=1), stay in IDLE without capturing until the word is accepted.
- WAIT_RDY (ACK_EARLY=0 only):
  - On dst_valid & dst_ready: dst_valid<=0, src_ack<=1, go to WAIT_REL.
  - If req_s falls while in this state: proto_err<=1; the word is still delivered and the FSM continues.
- WAIT_REL (src_ack=1):
  - On req_s=0: src_ack<=0, go to IDLE.
  - A new request is honoured only after a fresh req_s rise from IDLE, so one req pulse yields exactly one capture.
- Downstream handshake, any state:
  - A transfer occurs on any edge with dst_valid=1 and dst_ready=1.
  - dst_valid clears on that edge unless the same edge captures a new word.
  - dst_data is stable while dst_valid=1 and dst_ready=0.
  - dst_ready is ignored while dst_valid=0.
- xfer_count increments by 1 per downstream transfer and wraps modulo 2^COUNT_WIDTH.
- proto_err clears only on reset.
- Simultaneous capture and acceptance in one cycle (ACK_EARLY=1): the new word loads, dst_valid stays 1, and xfer_count increments.
- src_ack is driven straight from a flop, with no combinational path from any input.

Test Plan:
- Reset with src_req=1 held: release dst_rstn, then drive src_data=0xA5A5_0001 with dst_ready=1 (STAGES=4, ACK_EARLY=0) -> dst_valid rises 4 edges after the first sampled src_req; dst_data=0xA5A5_0001; src_ack rises the following edge and falls STAGES edges after src_req drops; xfer_count=1.
- Backpressure: dst_ready=0 for 20 cycles after capture of 0x1234 -> dst_valid=1 and dst_data=0x1234 held constant, src_ack=0 throughout; the edge after dst_ready=1 gives src_ack=1 and dst_valid=0.
- Ten back-to-back 4-phase transfers of values 0..9 from an initiator model with random dst_ready -> output sequence 0..9 with no duplicates or drops, xfer_count=10, proto_err=0.
- ACK_EARLY=1, dst_ready=0: first transfer of 0x11 -> src_ack rises without acceptance. Second request of 0x22 -> not captured and src_ack stays 0 until 0x11 is accepted; then 0x22 is captured.
- Protocol violation: src_req dropped before acceptance (ACK_EARLY=0) -> proto_err=1 and sticky; the word is still delivered once.
- Async reset asserted in WAIT_RDY with src_ack=0 and in WAIT_REL with src_ack=1 -> src_ack and dst_valid go to 0 immediately, before the next dst_clk edge; dst_data=RESET_VAL; xfer_count=0; proto_err=0.
- Counter wrap with COUNT_WIDTH=4: 17 transfers -> xfer_count=1.
